regfile_mp: RTL

Parametrised multi-port register file for the CPU datapath: N combinational read ports and two synchronous write ports with fixed priority. It adds write-to-read bypass, an optional hardwired zero register, and a sequential clear engine that zeroes every entry after reset or on request. It sits between decode (read addresses) and writeback (write ports). Its `busy` flag holds the pipeline off while the clear engine runs.

---
 rtl/regfile_mp_if.sv | 20 ++
 rtl/regfile_mp.sv | 88 ++++++++
 2 files changed

// File: rtl/regfile_mp_if.sv
// Port bundle for regfile_mp: read addresses/data, two write ports, clear request and busy flag.
interface regfile_mp_if #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned REGFILE_WIDTH = 5,
  parameter int unsigned NREAD         = 3
);
  logic [NREAD*REGFILE_WIDTH-1:0] ra;
  logic [NREAD*WIDTH-1:0]         rd;
  logic [REGFILE_WIDTH-1:0]       wa0;
  logic                           we0;
  logic [WIDTH-1:0]               wd0;
  logic [REGFILE_WIDTH-1:0]       wa1;
  logic                           we1;
  logic [WIDTH-1:0]               wd1;
  logic                           clr;
  logic                           busy;

  modport master (output ra, wa0, we0, wd0, wa1, we1, wd1, clr, input rd, busy);
  modport slave  (input ra, wa0, we0, wd0, wa1, we1, wd1, clr, output rd, busy);
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD combinational reads, two prioritised writes with bypass,
// optional hardwired zero entry, and a sequential clear sweep after reset or on request.
module regfile_mp #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned REGFILE_WIDTH = 5,
  parameter int unsigned NREAD         = 3,
  parameter int unsigned ZERO_REG      = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);
  localparam int unsigned SIZE = 2 ** REGFILE_WIDTH;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]               state, state_next;
  logic [REGFILE_WIDTH-1:0] cnt, cnt_next;
  logic                     busy_q;
  logic [WIDTH-1:0]         mem [SIZE];
  logic                     wr0_c, wr1_c;
  logic [NREAD*WIDTH-1:0]   rd_c;

  // Clear-engine state, sweep counter and busy flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_CLEAR;
      cnt    <= '0;
      busy_q <= 1'b1;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      busy_q <= (state_next == S_CLEAR);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_CLEAR: begin
        cnt_next = cnt + REGFILE_WIDTH'(1);
        if (cnt == REGFILE_WIDTH'(SIZE - 1)) state_next = S_IDLE;
      end
      default: begin
        if (bus.clr) begin
          state_next = S_CLEAR;
          cnt_next   = '0;
        end
      end
    endcase
  end

  // Only writes that will really commit this edge are allowed to bypass
  always_comb begin
    wr0_c = (state == S_IDLE) && bus.we0 && !((ZERO_REG != 0) && (bus.wa0 == '0));
    wr1_c = (state == S_IDLE) && bus.we1 && !((ZERO_REG != 0) && (bus.wa1 == '0));
  end

  // Storage has no reset; port 1 is written last so it wins on an address collision
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == S_CLEAR) begin
        mem[cnt] <= '0;
      end else begin
        if (wr0_c) mem[bus.wa0] <= bus.wd0;
        if (wr1_c) mem[bus.wa1] <= bus.wd1;
      end
    end
  end

  always_comb begin
    rd_c = '0;
    for (int i = 0; i < int'(NREAD); i++) begin
      logic [REGFILE_WIDTH-1:0] a;
      a = bus.ra[i*REGFILE_WIDTH +: REGFILE_WIDTH];
      if (state == S_CLEAR)                          rd_c[i*WIDTH +: WIDTH] = '0;
      else if ((ZERO_REG != 0) && (a == '0))         rd_c[i*WIDTH +: WIDTH] = '0;
      else if (wr1_c && (bus.wa1 == a))              rd_c[i*WIDTH +: WIDTH] = bus.wd1;
      else if (wr0_c && (bus.wa0 == a))              rd_c[i*WIDTH +: WIDTH] = bus.wd0;
      else                                           rd_c[i*WIDTH +: WIDTH] = mem[a];
    end
  end

  assign bus.rd   = rd_c;
  assign bus.busy = busy_q;
endmodule
